// File: rtl/fp_cvt_pkg.sv
// Shared types and helpers for float-to-integer conversion blocks.
package fp_cvt_pkg;

  typedef enum logic [2:0] {
    RTZ = 3'd0,
    RNA = 3'd1,
    RNE = 3'd2,
    RDN = 3'd3,
    RUP = 3'd4
  } rnd_mode_e;

  typedef enum logic [2:0] {
    ZERO,
    SUB,
    NORM,
    INF,
    NAN
  } fp_class_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic inexact;
  } cvt_flags_t;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational float field split: class, unbiased exponent, significand with hidden bit.
module fp_unpack
  import fp_cvt_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic [EXP_W+MAN_W:0]  fp,
  output logic                  sign,
  output fp_class_e             cls,
  output logic signed [EXP_W:0] exp_unb,
  output logic [MAN_W:0]        sig
);

  localparam logic [EXP_W-1:0]    EXP_MAX = '1;
  localparam logic signed [EXP_W:0] BIAS_S = (EXP_W+1)'(bias(EXP_W));

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac_f;

  assign sign   = fp[EXP_W+MAN_W];
  assign exp_f  = fp[EXP_W+MAN_W-1:MAN_W];
  assign frac_f = fp[MAN_W-1:0];

  always_comb begin
    exp_unb = $signed({1'b0, exp_f}) - BIAS_S;
    sig     = {|exp_f, frac_f};
    if (exp_f == '0)
      cls = (frac_f == '0) ? ZERO : SUB;
    else if (exp_f == EXP_MAX)
      cls = (frac_f == '0) ? INF : NAN;
    else
      cls = NORM;
  end

endmodule

// File: rtl/fp_to_int_pipe.sv
// Two-stage IEEE-754 float to signed integer converter with valid/ready handshake,
// run-time rounding mode and {invalid, overflow, inexact} flags.
module fp_to_int_pipe
  import fp_cvt_pkg::*;
#(
  parameter int EXP_W    = 11,
  parameter int MAN_W    = 52,
  parameter int INT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MAN_W:0]    in_fp,
  input  logic [2:0]              in_rnd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [INT_W-1:0] out_int,
  output logic [2:0]              out_flags
);

  // Fixed point: INT_W+1 integer bits above MAN_W+1 fraction bits (guard is the top one).
  localparam int FX_W = INT_W + MAN_W + 2;
  localparam logic signed [EXP_W:0] E_ONE = (EXP_W+1)'(1);
  localparam logic signed [EXP_W:0] E_LIM = (EXP_W+1)'(INT_W);
  localparam logic [INT_W+1:0] POS_LIM = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic [INT_W+1:0] NEG_LIM = {3'b001, {(INT_W-1){1'b0}}};

  function automatic logic round_inc(input logic [2:0] rnd, input logic sign,
                                     input logic lsb, input logic grd, input logic stk);
    case (rnd)
      RTZ:     return 1'b0;
      RNE:     return grd & (stk | lsb);
      RDN:     return sign & (grd | stk);
      RUP:     return ~sign & (grd | stk);
      default: return grd;  // RNA, also the unused encodings 5..7
    endcase
  endfunction

  function automatic logic [INT_W-1:0] sat_val(input logic sign);
    return sign ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
  endfunction

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // ---- stage 0: unpack and align ----
  logic                  sign_u;
  fp_class_e             cls_u;
  logic signed [EXP_W:0] exp_u;
  logic [MAN_W:0]        sig_u;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack (
    .fp      (in_fp),
    .sign    (sign_u),
    .cls     (cls_u),
    .exp_unb (exp_u),
    .sig     (sig_u)
  );

  logic signed [EXP_W:0] sh_p0;
  logic [FX_W-1:0]       fx_p0;
  logic [INT_W:0]        mag_p0;
  logic                  grd_p0, stk_p0, eovf_p0;

  // Bits shifted past the top are dropped, so mag keeps the value modulo 2**(INT_W+1),
  // which is what the wrapping overflow result needs.
  always_comb begin
    sh_p0   = exp_u + E_ONE;
    fx_p0   = '0;
    mag_p0  = '0;
    grd_p0  = 1'b0;
    stk_p0  = 1'b0;
    eovf_p0 = 1'b0;
    if (cls_u == SUB) begin
      stk_p0 = 1'b1;
    end else if (cls_u == NORM) begin
      if (sh_p0[EXP_W]) begin
        stk_p0 = 1'b1;
      end else begin
        fx_p0   = FX_W'(sig_u) << sh_p0;
        mag_p0  = fx_p0[FX_W-1 -: INT_W+1];
        grd_p0  = fx_p0[MAN_W];
        stk_p0  = |fx_p0[MAN_W-1:0];
        eovf_p0 = sh_p0 > E_LIM;
      end
    end
  end

  // ---- stage 1 registers ----
  logic           vld_p1, sign_p1, grd_p1, stk_p1, eovf_p1;
  fp_class_e      cls_p1;
  logic [INT_W:0] mag_p1;
  logic [2:0]     rnd_p1;

  always_ff @(posedge clk) begin
    if (!rst_n)
      vld_p1 <= 1'b0;
    else if (advance)
      vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      sign_p1 <= sign_u;
      cls_p1  <= cls_u;
      mag_p1  <= mag_p0;
      grd_p1  <= grd_p0;
      stk_p1  <= stk_p0;
      eovf_p1 <= eovf_p0;
      rnd_p1  <= in_rnd;
    end
  end

  // ---- stage 1 logic: round, negate, range check ----
  logic             inc_p1, rng_ovf_p1, ovf_p1;
  logic [INT_W+1:0] magr_p1;
  logic [INT_W-1:0] wrap_p1, res_p1;
  cvt_flags_t       flags_p1;

  always_comb begin
    inc_p1     = round_inc(rnd_p1, sign_p1, mag_p1[0], grd_p1, stk_p1);
    magr_p1    = {1'b0, mag_p1} + (INT_W+2)'(inc_p1);
    rng_ovf_p1 = sign_p1 ? (magr_p1 > NEG_LIM) : (magr_p1 > POS_LIM);
    ovf_p1     = eovf_p1 | rng_ovf_p1;
    wrap_p1    = sign_p1 ? -magr_p1[INT_W-1:0] : magr_p1[INT_W-1:0];
    res_p1     = (ovf_p1 && SATURATE) ? sat_val(sign_p1) : wrap_p1;
    flags_p1.invalid  = 1'b0;
    flags_p1.overflow = ovf_p1;
    flags_p1.inexact  = grd_p1 | stk_p1;
    case (cls_p1)
      NAN: begin
        res_p1   = '0;
        flags_p1 = '{invalid: 1'b1, overflow: 1'b0, inexact: 1'b0};
      end
      INF: begin
        res_p1   = SATURATE ? sat_val(sign_p1) : '0;
        flags_p1 = '{invalid: 1'b0, overflow: 1'b1, inexact: 1'b0};
      end
      default: ;
    endcase
  end

  // ---- stage 2 registers (outputs) ----
  logic             vld_p2;
  logic [INT_W-1:0] int_p2;
  cvt_flags_t       flags_p2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      int_p2   <= '0;
      flags_p2 <= '0;
    end else if (advance) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        int_p2   <= res_p1;
        flags_p2 <= flags_p1;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_int   = int_p2;
  assign out_flags = flags_p2;

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Scoreboard bench for fp_to_int_pipe: saturating and wrapping instances share stimulus.
module tb_fp_to_int_pipe;

  typedef struct packed {
    logic [7:0]  id;
    logic [63:0] fp;
    logic [2:0]  rnd;
    logic [31:0] i_sat;
    logic [2:0]  f_sat;
    logic [31:0] i_wrap;
    logic [2:0]  f_wrap;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b1;
  logic [63:0]        in_fp = '0;
  logic [2:0]         in_rnd = '0;
  logic               in_ready, out_valid, in_ready2, out_valid2;
  logic signed [31:0] out_int, out_int2;
  logic [2:0]         out_flags, out_flags2;

  int   n_chk = 0;
  int   n_pass = 0;
  int   rdy_mode = 0;
  int   send_cnt = 0;
  vec_t sb_q[$];
  vec_t dir[$];
  vec_t mon_e;

  always #5 clk = ~clk;

  fp_to_int_pipe #(.EXP_W(11), .MAN_W(52), .INT_W(32), .SATURATE(1'b1)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fp(in_fp), .in_rnd(in_rnd), .out_valid(out_valid), .out_ready(out_ready),
    .out_int(out_int), .out_flags(out_flags)
  );

  fp_to_int_pipe #(.EXP_W(11), .MAN_W(52), .INT_W(32), .SATURATE(1'b0)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_fp(in_fp), .in_rnd(in_rnd), .out_valid(out_valid2), .out_ready(out_ready),
    .out_int(out_int2), .out_flags(out_flags2)
  );

  task automatic check_val(input string tag, input logic signed [63:0] act,
                           input logic signed [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  function automatic vec_t mk(input logic [63:0] fp, input logic [2:0] rnd,
                              input logic [31:0] i_sat, input logic [2:0] f_sat,
                              input logic [31:0] i_wrap, input logic [2:0] f_wrap);
    vec_t v;
    v.id = '0; v.fp = fp; v.rnd = rnd;
    v.i_sat = i_sat; v.f_sat = f_sat; v.i_wrap = i_wrap; v.f_wrap = f_wrap;
    return v;
  endfunction

  // Caller is at a falling edge; returns at the next falling edge after acceptance.
  task automatic send(input vec_t v);
    int waits = 0;
    v.id = 8'(send_cnt);
    send_cnt++;
    in_valid = 1'b1; in_fp = v.fp; in_rnd = v.rnd;
    #1;
    while (!(in_ready && in_ready2) && waits < 50) begin
      @(negedge clk); #1;
      waits++;
    end
    if (in_ready && in_ready2) sb_q.push_back(v);
    else check_val("send_timeout", in_ready, 1);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    #2;
    check_val("drain", sb_q.size(), 0);
  endtask

  // out_ready pattern: 0 always ready, 1 -> 1,0,0 repeating, 2 held low.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (cnt == 0);
          cnt = (cnt == 2) ? 0 : cnt + 1;
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Compares every valid output cycle, so stalled outputs must keep matching the head.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst_n && (out_valid || out_valid2)) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_out", out_valid, 0);
          check_val("spurious_out2", out_valid2, 0);
        end else begin
          mon_e = sb_q[0];
          check_val($sformatf("v%0d_vld", mon_e.id), out_valid, 1);
          check_val($sformatf("v%0d_vld2", mon_e.id), out_valid2, 1);
          check_val($sformatf("v%0d_int_sat", mon_e.id), out_int, $signed(mon_e.i_sat));
          check_val($sformatf("v%0d_flg_sat", mon_e.id), out_flags, mon_e.f_sat);
          check_val($sformatf("v%0d_int_wrap", mon_e.id), out_int2, $signed(mon_e.i_wrap));
          check_val($sformatf("v%0d_flg_wrap", mon_e.id), out_flags2, mon_e.f_wrap);
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    dir.push_back(mk(64'h4222A05F20000000, 3'd1, 32'h7FFFFFFF, 3'b010, 32'd1345294336, 3'b010));
    dir.push_back(mk(64'h40017AE147AE147B, 3'd1, 2, 3'b001, 2, 3'b001));
    dir.push_back(mk(64'h40017AE147AE147B, 3'd4, 3, 3'b001, 3, 3'b001));
    dir.push_back(mk(64'h40017AE147AE147B, 3'd3, 2, 3'b001, 2, 3'b001));
    dir.push_back(mk(64'h4004000000000000, 3'd1, 3, 3'b001, 3, 3'b001));
    dir.push_back(mk(64'h4004000000000000, 3'd2, 2, 3'b001, 2, 3'b001));
    dir.push_back(mk(64'h4004000000000000, 3'd0, 2, 3'b001, 2, 3'b001));
    dir.push_back(mk(64'h4004000000000000, 3'd7, 3, 3'b001, 3, 3'b001));
    dir.push_back(mk(64'hC004000000000000, 3'd1, -3, 3'b001, -3, 3'b001));
    dir.push_back(mk(64'hC004000000000000, 3'd2, -2, 3'b001, -2, 3'b001));
    dir.push_back(mk(64'hC004000000000000, 3'd3, -3, 3'b001, -3, 3'b001));
    dir.push_back(mk(64'hC004000000000000, 3'd4, -2, 3'b001, -2, 3'b001));
    dir.push_back(mk(64'h7FF8000000000000, 3'd1, 0, 3'b100, 0, 3'b100));
    dir.push_back(mk(64'hFFF0000000000000, 3'd1, 32'h80000000, 3'b010, 0, 3'b010));
    dir.push_back(mk(64'h7FF0000000000000, 3'd0, 32'h7FFFFFFF, 3'b010, 0, 3'b010));
    dir.push_back(mk(64'hC1E0000000000000, 3'd2, 32'h80000000, 3'b000, 32'h80000000, 3'b000));
    dir.push_back(mk(64'h0000000000000000, 3'd4, 0, 3'b000, 0, 3'b000));
    dir.push_back(mk(64'h8000000000000000, 3'd3, 0, 3'b000, 0, 3'b000));
    dir.push_back(mk(64'h0000000000000001, 3'd4, 1, 3'b001, 1, 3'b001));
    dir.push_back(mk(64'h0000000000000001, 3'd0, 0, 3'b001, 0, 3'b001));
    dir.push_back(mk(64'h8000000000000001, 3'd3, -1, 3'b001, -1, 3'b001));
    dir.push_back(mk(64'h8000000000000001, 3'd1, 0, 3'b001, 0, 3'b001));
    dir.push_back(mk(64'h41DFFFFFFFE00000, 3'd1, 32'h7FFFFFFF, 3'b011, 32'h80000000, 3'b011));
    dir.push_back(mk(64'h41DFFFFFFFE00000, 3'd0, 32'h7FFFFFFF, 3'b001, 32'h7FFFFFFF, 3'b001));
    dir.push_back(mk(64'hC1E0000000100000, 3'd2, 32'h80000000, 3'b001, 32'h80000000, 3'b001));
    dir.push_back(mk(64'hC1E0000000100000, 3'd1, 32'h80000000, 3'b011, 32'h7FFFFFFF, 3'b011));

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_int", out_int, 0);
    check_val("rst_out_flags", out_flags, 0);
    check_val("rst_out_valid2", out_valid2, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_val("rst_in_ready", in_ready, 1);

    // Directed vectors, back to back with the consumer always ready
    @(negedge clk);
    foreach (dir[i]) send(dir[i]);
    in_valid = 1'b0;
    drain();

    // Eight-word stream against a stalling consumer
    rdy_mode = 1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      real r;
      int  e;
      r = -13.75 + 4.0 * real'(k);
      e = 4 * k - 14;
      send(mk($realtobits(r), 3'd1, e, 3'b001, e, 3'b001));
    end
    in_valid = 1'b0;
    drain();

    // Reset with two words in flight: neither may appear afterwards
    rdy_mode = 2;
    @(negedge clk);
    send(mk(64'h4004000000000000, 3'd1, 3, 3'b001, 3, 3'b001));
    send(mk(64'hC004000000000000, 3'd1, -3, 3'b001, -3, 3'b001));
    in_valid = 1'b0;
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_out_valid2", out_valid2, 0);
    check_val("midrst_out_int", out_int, 0);
    rdy_mode = 0;
    repeat (6) @(negedge clk);

    // Recovery after reset
    send(mk(64'h40017AE147AE147B, 3'd4, 3, 3'b001, 3, 3'b001));
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
